mc_sysbus: RTL and testbench

- Memory/MMIO subsystem directly downstream of the multicycle CPU core.
- Receives the core's `adr`, `writedata` and `MemWrite`; returns `readdata`.
- Contains a unified instruction/data word RAM, an LED output register, a synchronised switch input and a down-counting timer with interrupt.
- The core samples `readdata` into IR/DR at the clock edge, so reads are combinational and writes are synchronous.

---
 rtl/mc_sysbus_if.sv | 9 +
 rtl/mc_sysbus.sv | 77 +++++++
 tb/tb_mc_sysbus.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_sysbus_if.sv
// mc_sysbus_if: core-to-memory bus carrying address, store data, write strobe and read data.
interface mc_sysbus_if;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic        MemWrite;
   logic [31:0] readdata;
   modport master (output adr, writedata, MemWrite, input readdata);
   modport slave  (input adr, writedata, MemWrite, output readdata);
endinterface

// File: rtl/mc_sysbus.sv
// mc_sysbus: unified word RAM plus MMIO window (timer with interrupt, LED register, synchronised switches).
module mc_sysbus #(
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
) (
   input  logic          clk,
   input  logic          rst,
   mc_sysbus_if.slave    bus,
   input  logic [15:0]   sw,
   output logic [15:0]   led,
   output logic          irq
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset, count, mmio_rd;
   logic        irq_pending, mmio_sel, wr, ctrl_wr, fire;
   logic [15:0] sw_meta, sw_sync;
   logic [5:0]  reg_idx;
   logic        unused_adr;
   logic [31:0] mem [2**RAM_AW];
   assign mmio_sel   = bus.adr[31:8] == MMIO_BASE[31:8];
   assign reg_idx    = bus.adr[7:2];
   assign wr         = bus.MemWrite && mmio_sel;
   assign ctrl_wr    = wr && reg_idx == 6'd0;
   assign fire       = state == CNT && ctrl[0] && count <= 32'd1;
   assign irq        = irq_pending && ctrl[3];
   assign unused_adr = &{1'b0, bus.adr[1:0]};
   assign mmio_rd = reg_idx == 6'd0 ? {28'b0, ctrl} :
                    reg_idx == 6'd1 ? preset :
                    reg_idx == 6'd2 ? count :
                    reg_idx == 6'd3 ? {31'b0, irq_pending} :
                    reg_idx == 6'd4 ? {16'b0, led} :
                    reg_idx == 6'd5 ? {16'b0, sw_sync} : 32'b0;
   assign bus.readdata = mmio_sel ? mmio_rd : mem[bus.adr[RAM_AW+1:2]];
   always_ff @(posedge clk)
      if (bus.MemWrite && !mmio_sel) mem[bus.adr[RAM_AW+1:2]] <= bus.writedata;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ctrl        <= '0;
         preset      <= '0;
         count       <= '0;
         irq_pending <= 1'b0;
         led         <= '0;
         sw_meta     <= '0;
         sw_sync     <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         if (wr && reg_idx == 6'd1) preset <= bus.writedata;
         if (wr && reg_idx == 6'd4) led <= bus.writedata[15:0];
         case (state)
            IDLE: if (ctrl[0]) state <= LOAD;
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT:
               if (!ctrl[0]) state <= IDLE;
               else if (count <= 32'd1) begin
                  count <= '0;
                  state <= INT;
               end else count <= count - 32'd1;
            INT:
               if (ctrl[2:1] == 2'b01) state <= LOAD;
               else begin
                  ctrl[0] <= 1'b0;
                  state   <= IDLE;
               end
         endcase
         // placed after the FSM so a same-cycle CPU write overrides the one-shot EN clear
         if (ctrl_wr) ctrl <= bus.writedata[3:0];
         irq_pending <= fire ? 1'b1 : ctrl_wr ? 1'b0 : irq_pending;
      end
   end
endmodule

// File: tb/tb_mc_sysbus.sv
// tb_mc_sysbus: randomized RAM/MMIO traffic plus timer scenarios checked against closed-form timing rules.
module tb_mc_sysbus;
   localparam logic [31:0] CTRL_A = 32'h7F00, PRESET_A = 32'h7F04, COUNT_A = 32'h7F08,
                           STATUS_A = 32'h7F0C, LED_A = 32'h7F10, SW_A = 32'h7F14;
   logic        clk = 1'b0, rst = 1'b0, irq;
   logic [15:0] sw = '0, led;
   logic [31:0] rdv;
   int          n_checks = 0, n_errors = 0;
   mc_sysbus_if bus();
   mc_sysbus dut (.clk(clk), .rst(rst), .bus(bus), .sw(sw), .led(led), .irq(irq));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.adr = a;
      bus.writedata = d;
      bus.MemWrite = 1'b1;
      tick();
      bus.MemWrite = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.adr = a;
      #1;
      d = bus.readdata;
   endtask

   task automatic one_shot(input logic [31:0] n);
      int fire_k;
      fire_k = (n == 0 ? 1 : int'(n)) + 2;
      wr(PRESET_A, n);
      wr(CTRL_A, 32'h9);
      for (int k = 1; k <= fire_k + 1; k++) begin
         tick();
         check("oneshot_irq", {31'b0, irq}, {31'b0, k >= fire_k});
         if (k == 2) begin
            rd(COUNT_A, rdv);
            check("oneshot_load", rdv, n);
         end
      end
      rd(COUNT_A, rdv);
      check("oneshot_count0", rdv, 0);
      rd(CTRL_A, rdv);
      check("oneshot_ctrl", rdv, 32'h8);
      repeat (3) tick();
      rd(COUNT_A, rdv);
      check("oneshot_idle_count", rdv, 0);
      wr(CTRL_A, 32'h8);
      check("oneshot_irq_clr", {31'b0, irq}, 0);
   endtask

   task automatic auto_reload(input int n);
      wr(PRESET_A, n);
      wr(CTRL_A, 32'hB);
      for (int k = 1; k <= 3 * (n + 2) + 2; k++) begin
         tick();
         if (k >= 2) begin
            int j;
            j = (k - 2) % (n + 2);
            rd(COUNT_A, rdv);
            check("reload_count", rdv, j < n ? n - j : 0);
         end
         if (k == n + 1) check("reload_irq_pre", {31'b0, irq}, 0);
         if (k == n + 2) begin
            rd(STATUS_A, rdv);
            check("reload_status", rdv, 1);
            check("reload_irq", {31'b0, irq}, 1);
         end
      end
      wr(CTRL_A, 0);
      repeat (3) tick();
      wr(CTRL_A, 0);
   endtask

   initial begin
      int          ram_m [int];
      int          keys [$];
      logic [31:0] a, d, sw_prev;
      bus.adr = '0;
      bus.writedata = '0;
      bus.MemWrite = 1'b0;
      #12;
      check("rst_led", {16'b0, led}, 0);
      check("rst_irq", {31'b0, irq}, 0);
      rd(CTRL_A, rdv);   check("rst_ctrl", rdv, 0);
      rd(PRESET_A, rdv); check("rst_preset", rdv, 0);
      rd(COUNT_A, rdv);  check("rst_count", rdv, 0);
      rd(STATUS_A, rdv); check("rst_status", rdv, 0);
      rst = 1'b1;
      tick();
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rd(32'h0000_0010, rdv); check("ram_rd", rdv, 32'hDEAD_BEEF);
      rd(32'h0000_1010, rdv); check("ram_alias", rdv, 32'hDEAD_BEEF);
      ram_m[4] = 32'hDEAD_BEEF;
      keys.push_back(4);
      wr(LED_A, 32'h1234_A5A5);
      check("led_out", {16'b0, led}, 32'h0000_A5A5);
      rd(LED_A, rdv); check("led_rd", rdv, 32'h0000_A5A5);
      sw = 16'h0F0F;
      tick();
      rd(SW_A, rdv); check("sw_1cyc", rdv, 0);
      tick();
      rd(SW_A, rdv); check("sw_2cyc", rdv, 32'h0000_0F0F);
      sw_prev = 32'h0F0F;
      rd(32'h7F40, rdv); check("unmapped", rdv, 0);
      for (int i = 0; i < 200; i++) begin
         int op;
         op = $urandom_range(0, 5);
         a = $urandom;
         d = $urandom;
         if (a[31:8] == 24'h00007F) a[31] = 1'b1;
         case (op)
            0: begin
               wr(a, d);
               if (!ram_m.exists(int'(a[11:2]))) keys.push_back(int'(a[11:2]));
               ram_m[int'(a[11:2])] = d;
            end
            1: begin
               a[11:2] = 10'(keys[$urandom_range(0, keys.size() - 1)]);
               rd(a, rdv);
               check("ram_rand", rdv, ram_m[int'(a[11:2])]);
            end
            2: begin
               wr(LED_A, d);
               rd(LED_A, rdv);
               check("led_rand", rdv, {16'b0, d[15:0]});
            end
            3: begin
               wr(PRESET_A, d);
               rd(PRESET_A, rdv);
               check("preset_rand", rdv, d);
            end
            4: begin
               sw = d[15:0];
               tick();
               rd(SW_A, rdv); check("sw_rand_1", rdv, sw_prev);
               tick();
               rd(SW_A, rdv); check("sw_rand_2", rdv, {16'b0, d[15:0]});
               sw_prev = {16'b0, d[15:0]};
            end
            default: begin
               rd({24'h00007F, 6'($urandom_range(6, 63)), 2'(d)}, rdv);
               check("unmapped_rand", rdv, 0);
               wr({24'h00007F, 8'h08}, d);
               rd(COUNT_A, rdv);
               check("count_ro", rdv, 0);
            end
         endcase
      end
      one_shot(5);
      one_shot(0);
      one_shot(1);
      one_shot($urandom_range(2, 20));
      auto_reload(3);
      auto_reload($urandom_range(2, 7));
      wr(PRESET_A, 4);
      wr(CTRL_A, 32'h1);
      repeat (7) tick();
      rd(STATUS_A, rdv); check("mask_status", rdv, 1);
      check("mask_irq", {31'b0, irq}, 0);
      wr(CTRL_A, 0);
      wr(PRESET_A, 50);
      wr(CTRL_A, 32'h1);
      repeat (10) tick();
      rd(COUNT_A, rdv); check("dis_mid", rdv, 42);
      wr(CTRL_A, 0);
      repeat (5) tick();
      rd(COUNT_A, rdv); check("dis_freeze", rdv, 41);
      rd(STATUS_A, rdv); check("dis_status", rdv, 0);
      wr(LED_A, 32'h00FF);
      wr(PRESET_A, 200);
      wr(CTRL_A, 32'h9);
      repeat (102) tick();
      rd(COUNT_A, rdv); check("rst_mid_count", rdv, 100);
      check("rst_mid_led_pre", {16'b0, led}, 32'h00FF);
      #1 rst = 1'b0;
      #1;
      check("rst_mid_led", {16'b0, led}, 0);
      check("rst_mid_irq", {31'b0, irq}, 0);
      rd(COUNT_A, rdv); check("rst_mid_cnt0", rdv, 0);
      tick();
      rst = 1'b1;
      repeat (300) tick();
      check("rst_post_irq", {31'b0, irq}, 0);
      rd(STATUS_A, rdv); check("rst_post_status", rdv, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
